// File: rtl/raster_scan_generator_pkg.sv
// -----------------------------------------------------------------------------
// raster_scan_generator_pkg
// Shared definitions for the Loader raster-scan path: the scan FSM state
// encoding and the default coordinate/address/kernel sizes used by the Loader.
// -----------------------------------------------------------------------------
package raster_scan_generator_pkg;

   // Scan FSM states: waiting for a frame request, or walking a frame.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_e;

   // Default geometry used by the Loader instance.
   localparam int DEF_COORD_W = 8;
   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_KERNEL  = 3;

endpackage : raster_scan_generator_pkg

// File: rtl/raster_scan_generator_axis_counter.sv
// -----------------------------------------------------------------------------
// raster_scan_generator_axis_counter
// One axis (row or column) of the raster walk: counts 0..limit-1 and wraps.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - synchronous active-low reset
//   clear_i  - force count to 0 (dominates enable)
//   enable_i - advance the count by one
//   limit_i  - runtime number of positions on this axis
//   count_o  - current position
//   wrap_o   - high when an enabled step leaves the last position
// -----------------------------------------------------------------------------
module raster_scan_generator_axis_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic [CNT_W-1:0] count_o,
   output logic             wrap_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             at_last_s;

   // Detect the last position of the axis and the resulting wrap.
   always_comb begin
      at_last_s = (count_q == (limit_i - CNT_W'(1)));
      wrap_o    = enable_i && at_last_s;
   end

   // Next count: clear wins, otherwise step with wrap to zero.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         if (at_last_s) begin
            count_d = '0;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule : raster_scan_generator_axis_counter

// File: rtl/raster_scan_generator.sv
// -----------------------------------------------------------------------------
// raster_scan_generator
// Walks a runtime-programmable WxH image in row-major order under a
// valid/ready handshake, emitting row, column, linear address, a KERNELxKERNEL
// window-valid flag and frame start/end markers.
// Ports:
//   CLK          - clock, rising edge
//   Reset        - synchronous active-low reset
//   Start        - frame request, honoured only in IDLE with non-zero dims
//   Abort        - terminate the current frame (ignored in IDLE)
//   Img_Width    - pixels per row, latched on accepted Start
//   Img_Height   - rows per frame, latched on accepted Start
//   Out_Ready    - downstream accepts the current beat
//   Out_Valid    - current beat valid
//   Out_Row      - current row
//   Out_Column   - current column
//   Out_Addr     - row*W + column (maintained incrementally)
//   Window_Valid - full KERNELxKERNEL neighbourhood available at this beat
//   Frame_Start  - beat is (0,0)
//   Frame_End    - beat is (H-1,W-1)
//   Busy         - frame in progress
// -----------------------------------------------------------------------------
module raster_scan_generator
   import raster_scan_generator_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int KERNEL  = DEF_KERNEL
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Abort,
   input  logic [COORD_W-1:0] Img_Width,
   input  logic [COORD_W-1:0] Img_Height,
   input  logic               Out_Ready,
   output logic               Out_Valid,
   output logic [COORD_W-1:0] Out_Row,
   output logic [COORD_W-1:0] Out_Column,
   output logic [ADDR_W-1:0]  Out_Addr,
   output logic               Window_Valid,
   output logic               Frame_Start,
   output logic               Frame_End,
   output logic               Busy
);

   scan_state_e        state_q;
   logic [COORD_W-1:0] width_q;
   logic [COORD_W-1:0] height_q;
   logic [ADDR_W-1:0]  addr_q;

   logic               scan_s;
   logic               abort_s;
   logic               accept_s;
   logic               start_s;
   logic               last_s;
   logic               clear_s;
   logic               col_wrap_s;
   logic               row_wrap_s;
   logic [COORD_W-1:0] row_s;
   logic [COORD_W-1:0] col_s;

   // Handshake decode; Abort outranks a beat acceptance in the same cycle.
   always_comb begin
      scan_s   = (state_q == ST_SCAN);
      abort_s  = scan_s && Abort;
      accept_s = scan_s && Out_Ready && !Abort;
      start_s  = !scan_s && Start && (Img_Width != '0) && (Img_Height != '0);
      // Row counter only steps on a column wrap, so its wrap marks the final beat.
      last_s   = col_wrap_s && row_wrap_s;
      clear_s  = abort_s || start_s || last_s;
   end

   raster_scan_generator_axis_counter #(
      .CNT_W (COORD_W)
   ) u_col_cnt (
      .clk_i    (CLK),
      .rst_ni   (Reset),
      .clear_i  (clear_s),
      .enable_i (accept_s),
      .limit_i  (width_q),
      .count_o  (col_s),
      .wrap_o   (col_wrap_s)
   );

   raster_scan_generator_axis_counter #(
      .CNT_W (COORD_W)
   ) u_row_cnt (
      .clk_i    (CLK),
      .rst_ni   (Reset),
      .clear_i  (clear_s),
      .enable_i (col_wrap_s),
      .limit_i  (height_q),
      .count_o  (row_s),
      .wrap_o   (row_wrap_s)
   );

   // Scan FSM with latched dimensions and incremental linear address.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         width_q  <= '0;
         height_q <= '0;
         addr_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_s) begin
                  state_q  <= ST_SCAN;
                  width_q  <= Img_Width;
                  height_q <= Img_Height;
                  addr_q   <= '0;
               end
            end
            ST_SCAN: begin
               if (abort_s) begin
                  state_q <= ST_IDLE;
                  addr_q  <= '0;
               end else if (accept_s) begin
                  if (last_s) begin
                     state_q <= ST_IDLE;
                     addr_q  <= '0;
                  end else begin
                     addr_q <= addr_q + ADDR_W'(1);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               addr_q  <= '0;
            end
         endcase
      end
   end

   assign Out_Valid  = scan_s;
   assign Busy       = scan_s;
   assign Out_Row    = row_s;
   assign Out_Column = col_s;
   assign Out_Addr   = addr_q;

   // Beat flags decoded from registered state, all qualified by a live beat.
   always_comb begin
      Window_Valid = scan_s && (row_s >= COORD_W'(KERNEL - 1))
                            && (col_s >= COORD_W'(KERNEL - 1));
      Frame_Start  = scan_s && (row_s == '0) && (col_s == '0);
      Frame_End    = scan_s && (row_s == (height_q - COORD_W'(1)))
                            && (col_s == (width_q - COORD_W'(1)));
   end

endmodule : raster_scan_generator

// File: tb/tb_raster_scan_generator.sv
// -----------------------------------------------------------------------------
// tb_raster_scan_generator
// Scoreboard bench: stimulus pushes the expected beat sequence of each frame
// into a queue; a monitor compares every presented beat with the queue head
// and pops it when the beat is accepted.
// -----------------------------------------------------------------------------
module tb_raster_scan_generator;

   logic       CLK = 1'b0;
   logic       Reset;
   logic       Start;
   logic       Abort;
   logic [7:0] Img_Width;
   logic [7:0] Img_Height;
   logic       Out_Ready;
   logic       Out_Valid;
   logic [7:0] Out_Row;
   logic [7:0] Out_Column;
   logic [15:0] Out_Addr;
   logic       Window_Valid;
   logic       Frame_Start;
   logic       Frame_End;
   logic       Busy;

   typedef struct {
      int row;
      int col;
      int addr;
      bit wv;
      bit fs;
      bit fe;
   } beat_t;

   beat_t exp_q[$];
   int    n_cmp = 0;
   int    n_mis = 0;
   int    n;

   raster_scan_generator dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .Start        (Start),
      .Abort        (Abort),
      .Img_Width    (Img_Width),
      .Img_Height   (Img_Height),
      .Out_Ready    (Out_Ready),
      .Out_Valid    (Out_Valid),
      .Out_Row      (Out_Row),
      .Out_Column   (Out_Column),
      .Out_Addr     (Out_Addr),
      .Window_Valid (Window_Valid),
      .Frame_Start  (Frame_Start),
      .Frame_End    (Frame_End),
      .Busy         (Busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Expected beats of a full WxH frame with a 3x3 window.
   task automatic push_frame(input int w, input int h);
      beat_t b;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            b.row  = r;
            b.col  = c;
            b.addr = r * w + c;
            b.wv   = (r >= 2) && (c >= 2);
            b.fs   = (r == 0) && (c == 0);
            b.fe   = (r == h - 1) && (c == w - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic start_frame(input int w, input int h);
      Img_Width  = 8'(w);
      Img_Height = 8'(h);
      Start      = 1'b1;
      tick();
      Start      = 1'b0;
   endtask

   // Run until Out_Valid drops; optional mid-frame Start and random stalls.
   task automatic run_until_idle(input int budget, input int restart_at,
                                 input bit rand_ready, output int cycles);
      cycles = 0;
      while (Out_Valid && cycles < budget) begin
         Start = (cycles == restart_at);
         if (cycles == restart_at) begin
            Img_Width  = 8'd2;
            Img_Height = 8'd2;
         end
         if (rand_ready) Out_Ready = 1'($urandom_range(0, 1));
         tick();
         cycles++;
      end
      Start     = 1'b0;
      Out_Ready = 1'b1;
      check("frame_completes_in_budget", int'(Out_Valid), 0);
      check("scoreboard_drained", exp_q.size(), 0);
      check("busy_low_after_frame", int'(Busy), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, int'(Out_Valid), 0);
      check({tag, "_busy"},  int'(Busy), 0);
      check({tag, "_row"},   int'(Out_Row), 0);
      check({tag, "_col"},   int'(Out_Column), 0);
      check({tag, "_addr"},  int'(Out_Addr), 0);
      check({tag, "_flags"}, int'({Window_Valid, Frame_Start, Frame_End}), 0);
   endtask

   // Monitor: compare every live beat with the scoreboard head, pop on accept.
   always @(negedge CLK) begin
      if (Reset === 1'b1 && Out_Valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
         end else begin
            check("beat_row",   int'(Out_Row),      exp_q[0].row);
            check("beat_col",   int'(Out_Column),   exp_q[0].col);
            check("beat_addr",  int'(Out_Addr),     exp_q[0].addr);
            check("beat_win",   int'(Window_Valid), int'(exp_q[0].wv));
            check("beat_fs",    int'(Frame_Start),  int'(exp_q[0].fs));
            check("beat_fe",    int'(Frame_End),    int'(exp_q[0].fe));
            if (Out_Ready && !Abort) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      Reset = 1'b0; Start = 1'b0; Abort = 1'b0; Out_Ready = 1'b0;
      Img_Width = 8'd0; Img_Height = 8'd0;
      repeat (3) tick();
      check_all_zero("reset");
      Reset = 1'b1;
      tick();

      // 4x3 frame, Out_Ready held high: exactly 12 beat cycles.
      Out_Ready = 1'b1;
      push_frame(4, 3);
      start_frame(4, 3);
      check("busy_after_start", int'(Busy), 1);
      run_until_idle(100, -1, 1'b0, n);
      check("frame_4x3_cycles", n, 12);

      // Same frame with random stalls; monitor checks hold on stall cycles.
      push_frame(4, 3);
      start_frame(4, 3);
      run_until_idle(400, -1, 1'b1, n);

      // 1x1 frame: single beat carrying both markers.
      push_frame(1, 1);
      start_frame(1, 1);
      run_until_idle(10, -1, 1'b0, n);
      check("frame_1x1_cycles", n, 1);

      // Zero dimensions are ignored.
      start_frame(0, 3);
      check("zero_w_valid", int'(Out_Valid), 0);
      check("zero_w_busy",  int'(Busy), 0);
      start_frame(5, 0);
      check("zero_h_valid", int'(Out_Valid), 0);
      check("zero_h_busy",  int'(Busy), 0);

      // Start during SCAN does not restart the frame.
      push_frame(4, 3);
      start_frame(4, 3);
      run_until_idle(100, 3, 1'b0, n);
      check("start_in_scan_cycles", n, 12);

      // Abort while beat 5 is presented.
      push_frame(4, 3);
      start_frame(4, 3);
      repeat (5) tick();
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      check_all_zero("abort");
      exp_q.delete();
      push_frame(4, 3);
      start_frame(4, 3);
      run_until_idle(100, -1, 1'b0, n);
      check("after_abort_cycles", n, 12);

      // Reset at beat 7 with Abort and Out_Ready also high.
      push_frame(4, 3);
      start_frame(4, 3);
      repeat (7) tick();
      Reset = 1'b0;
      Abort = 1'b1;
      tick();
      Reset = 1'b1;
      Abort = 1'b0;
      check_all_zero("midreset");
      exp_q.delete();
      push_frame(3, 2);
      start_frame(3, 2);
      run_until_idle(100, -1, 1'b0, n);
      check("after_reset_cycles", n, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_raster_scan_generator

// File: doc/raster_scan_generator.md
# raster_scan_generator

Parametrised raster-scan coordinate and address generator for the Loader, succeeding the fixed 8-bit row/column counter. It walks a runtime-programmable WxH image in row-major order under a valid/ready handshake and emits row, column, a linear pixel address, a KxK window-valid flag for the Sobel stage, and frame start/end markers. It sits between the frame-control logic and the pixel buffer/line-buffer read path.

## Interface
- COORD_W, 8, width of row/column coordinates and of Img_Width/Img_Height
- ADDR_W, 16, width of linear address; W*H must not exceed 2^ADDR_W
- KERNEL, 3, window size; Window_Valid asserts once a full KERNEL x KERNEL neighbourhood exists
- CLK  input  1  single clock, rising edge
- Reset  input  1  synchronous, active-low reset
- Start  input  1  one-cycle request to begin a frame; sampled only in IDLE
- Abort  input  1  terminate the current frame
- Img_Width  input  COORD_W  pixels per row, latched on accepted Start
- Img_Height  input  COORD_W  rows per frame, latched on accepted Start
- Out_Ready  input  1  downstream accepts current beat
- Out_Valid  output  1  current coordinate beat is valid
- Out_Row  output  COORD_W  current row
- Out_Column  output  COORD_W  current column
- Out_Addr  output  ADDR_W  row*W + column
- Window_Valid  output  1  Out_Valid && row >= KERNEL-1 && column >= KERNEL-1
- Frame_Start  output  1  Out_Valid && beat is (0,0)
- Frame_End  output  1  Out_Valid && beat is (H-1,W-1)
- Busy  output  1  high in SCAN

## Operation
- States: IDLE, SCAN. Reset (Reset=0 at edge) -> IDLE; all outputs 0, coordinates and address 0, latched dims 0.
- IDLE: Start=1 with Img_Width!=0 and Img_Height!=0 -> latch dims, coords/address to 0, go SCAN. Start with either dim 0 is ignored (stay IDLE).
- SCAN: Out_Valid=1. Beat accepted when Out_Valid && Out_Ready. On accept: column+1, address+1; if column==W-1, column->0 and row+1; if also row==H-1, go IDLE (coords/address return to 0).
- No accept: all outputs hold stable (no change while stalled).
- Start in SCAN ignored; Img_Width/Img_Height changes in SCAN have no effect.
- Abort in SCAN -> IDLE next cycle, coords/address 0, no Frame_End emitted. Abort in IDLE ignored.
- Priority: Reset > Abort > accept > Start.
- Address maintained incrementally (no multiplier); wraps mod 2^ADDR_W if the size rule is violated (unsupported).
- Window_Valid, Frame_Start, Frame_End are combinational from registered state; all gated by Out_Valid.
- W=1 and/or H=1 legal: Frame_Start and Frame_End may assert on the same beat.

## Timing
- Start accepted at edge N -> Out_Valid=1 with (0,0) from edge N+1 (latency 1).
- Throughput 1 beat/cycle with Out_Ready held high; a WxH frame occupies exactly W*H SCAN cycles.
- Last beat accepted at edge M -> Out_Valid=0, Busy=0 after M; next Start earliest sampled at edge M+1.
- Abort at edge N -> Out_Valid=0 after N.
- Reset mid-frame: IDLE after that edge regardless of Abort/Out_Ready.

## Structure
- Shared package: state enum (IDLE, SCAN), default COORD_W/ADDR_W/KERNEL constants used by the Loader.
- Sub-module axis_counter (COORD_W): runtime limit input, clear, enable, count output, wrap flag (count==limit-1 && enable); instantiated for column (enable=accept) and row (enable=column wrap).
- Top holds FSM, dimension registers, address register, flag decode.

## Test plan
- W=4,H=3,Out_Ready=1, Start pulse -> 12 beats, coords (0,0)..(2,3), Out_Addr 0..11, Frame_Start on beat 0 only, Frame_End on beat 11 only, Window_Valid on (2,2),(2,3) only; Busy low after.
- Same frame, Out_Ready toggled randomly -> identical beat sequence; outputs unchanged on every Out_Ready=0 cycle.
- W=1,H=1 -> single beat with Frame_Start=Frame_End=1, Window_Valid=0.
- Start with W=0 or H=0 -> stays IDLE, Out_Valid=0; Start during SCAN -> no restart, sequence continues.
- Abort at beat 5 of 4x3 -> Out_Valid=0 next cycle, no Frame_End; new Start then restarts at (0,0), address 0.
- Reset=0 at beat 7 with Out_Ready=1 and Abort=1 -> all outputs 0, IDLE next cycle.
